// File: rtl/hook_ctrl.sv
// Gold Miner hook motion controller: swing, extend on drop, retract empty or loaded.
// Optional HOOK_WEIGHT_EN: a carried stone retracts at the slow step instead of the fast one.
module hook_ctrl (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame,
    input  logic       drop,
    input  logic       hit,
    input  logic       hit_gold,
    input  logic       game_end,
    output logic [6:0] angle,
    output logic [7:0] length,
    output logic       clockwise,
    output logic       drop_end,
    output logic       drag_end,
    output logic       busy,
    output logic       collect,
    output logic       collect_gold
);

    localparam logic [6:0] ANGLE_MAX      = 7'd80;
    localparam logic [6:0] ANGLE_CENTER   = ANGLE_MAX >> 1;
    localparam logic [7:0] LEN_MIN        = 8'd16;
    localparam logic [7:0] LEN_MAX        = 8'd120;
    localparam logic [7:0] DROP_STEP      = 8'd4;
    localparam logic [7:0] DRAG_STEP_FAST = 8'd4;
`ifdef HOOK_WEIGHT_EN
    localparam logic [7:0] DRAG_STEP_SLOW = 8'd1;
`endif

    typedef enum logic [1:0] {SWING, DROP, DRAG, HALT} state_t;

    state_t     state_q, state_d;
    logic [6:0] angle_q, angle_d;
    logic [7:0] length_q, length_d;
    logic       clockwise_q, clockwise_d;
    logic       drop_end_q, drop_end_d;
    logic       drag_end_q, drag_end_d;
    logic       busy_q, busy_d;
    logic       collect_q, collect_d;
    logic       collect_gold_q, collect_gold_d;
    logic       carrying_q, carrying_d;
    logic       carry_gold_q, carry_gold_d;

    logic [7:0] drag_step;
    logic [8:0] len_sum;
    logic [8:0] len_diff;
    logic [6:0] angle_inc;
    logic [6:0] angle_dec;

`ifdef HOOK_WEIGHT_EN
    assign drag_step = (carrying_q && !carry_gold_q) ? DRAG_STEP_SLOW : DRAG_STEP_FAST;
`else
    assign drag_step = DRAG_STEP_FAST;
`endif

    assign len_sum   = {1'b0, length_q} + {1'b0, DROP_STEP};
    assign len_diff  = {1'b0, length_q} - {1'b0, drag_step};
    assign angle_inc = angle_q + 7'd1;
    assign angle_dec = angle_q - 7'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= SWING;
            angle_q        <= ANGLE_CENTER;
            length_q       <= LEN_MIN;
            clockwise_q    <= 1'b1;
            drop_end_q     <= 1'b0;
            drag_end_q     <= 1'b0;
            busy_q         <= 1'b0;
            collect_q      <= 1'b0;
            collect_gold_q <= 1'b0;
            carrying_q     <= 1'b0;
            carry_gold_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            angle_q        <= angle_d;
            length_q       <= length_d;
            clockwise_q    <= clockwise_d;
            drop_end_q     <= drop_end_d;
            drag_end_q     <= drag_end_d;
            busy_q         <= busy_d;
            collect_q      <= collect_d;
            collect_gold_q <= collect_gold_d;
            carrying_q     <= carrying_d;
            carry_gold_q   <= carry_gold_d;
        end
    end

    // game_end overrides every transition; the extent checks use the registered length.
    always_comb begin
        state_d = state_q;
        if (game_end) begin
            state_d = HALT;
        end else begin
            case (state_q)
                SWING:   if (drop) state_d = DROP;
                DROP:    if (hit || (length_q == LEN_MAX)) state_d = DRAG;
                DRAG:    if (length_q == LEN_MIN) state_d = SWING;
                default: state_d = SWING;
            endcase
        end
    end

    always_comb begin
        angle_d        = angle_q;
        length_d       = length_q;
        clockwise_d    = clockwise_q;
        drop_end_d     = 1'b0;
        drag_end_d     = 1'b0;
        collect_d      = 1'b0;
        collect_gold_d = 1'b0;
        carrying_d     = carrying_q;
        carry_gold_d   = carry_gold_q;
        busy_d         = (state_d == DROP) || (state_d == DRAG);

        if (state_d == HALT) begin
            length_d     = LEN_MIN;
            carrying_d   = 1'b0;
            carry_gold_d = 1'b0;
        end else begin
            case (state_q)
                SWING: begin
                    if ((state_d == SWING) && frame) begin
                        if (clockwise_q) begin
                            angle_d = angle_inc;
                            if (angle_inc == ANGLE_MAX) clockwise_d = 1'b0;
                        end else begin
                            angle_d = angle_dec;
                            if (angle_dec == 7'd0) clockwise_d = 1'b1;
                        end
                    end
                end
                DROP: begin
                    // A hit pre-empts the frame advance in the same cycle.
                    if (state_d == DRAG) begin
                        drop_end_d = 1'b1;
                        if (hit) begin
                            carrying_d   = 1'b1;
                            carry_gold_d = hit_gold;
                        end
                    end else if (frame) begin
                        length_d = (len_sum > {1'b0, LEN_MAX}) ? LEN_MAX : len_sum[7:0];
                    end
                end
                DRAG: begin
                    if (state_d == SWING) begin
                        drag_end_d     = 1'b1;
                        collect_d      = carrying_q;
                        collect_gold_d = carrying_q & carry_gold_q;
                        carrying_d     = 1'b0;
                        carry_gold_d   = 1'b0;
                    end else if (frame) begin
                        length_d = (len_diff[8] || (len_diff[7:0] < LEN_MIN)) ? LEN_MIN : len_diff[7:0];
                    end
                end
                default: begin
                    if (state_d == SWING) begin
                        angle_d     = ANGLE_CENTER;
                        clockwise_d = 1'b1;
                    end
                end
            endcase
        end
    end

    assign angle        = angle_q;
    assign length       = length_q;
    assign clockwise    = clockwise_q;
    assign drop_end     = drop_end_q;
    assign drag_end     = drag_end_q;
    assign busy         = busy_q;
    assign collect      = collect_q;
    assign collect_gold = collect_gold_q;

endmodule

// File: tb/tb_hook_ctrl.sv
// Self-checking bench for hook_ctrl: scenario tasks plus a scoreboard of expected drop_end/drag_end events.
module tb_hook_ctrl;

`ifdef HOOK_WEIGHT_EN
    localparam int STONE_STEP = 1;
`else
    localparam int STONE_STEP = 4;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       frame = 1'b0;
    logic       drop = 1'b0;
    logic       hit = 1'b0;
    logic       hit_gold = 1'b0;
    logic       game_end = 1'b0;
    logic [6:0] angle;
    logic [7:0] length;
    logic       clockwise;
    logic       drop_end;
    logic       drag_end;
    logic       busy;
    logic       collect;
    logic       collect_gold;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       is_drag;
        logic       coll;
        logic       cgold;
        logic [7:0] len;
        logic [6:0] ang;
    } ev_t;

    ev_t exp_q[$];

    hook_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .frame        (frame),
        .drop         (drop),
        .hit          (hit),
        .hit_gold     (hit_gold),
        .game_end     (game_end),
        .angle        (angle),
        .length       (length),
        .clockwise    (clockwise),
        .drop_end     (drop_end),
        .drag_end     (drag_end),
        .busy         (busy),
        .collect      (collect),
        .collect_gold (collect_gold)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic ev_t mk_ev(input logic is_drag, input logic coll, input logic cgold,
                                  input logic [7:0] len, input logic [6:0] ang);
        ev_t e;
        e.is_drag = is_drag;
        e.coll    = coll;
        e.cgold   = cgold;
        e.len     = len;
        e.ang     = ang;
        return e;
    endfunction

    // Advance one clock, then consume any pulse the DUT produced against the scoreboard.
    task automatic cyc();
        ev_t e;
        @(posedge clk);
        #1;
        if (drop_end || drag_end) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got drop_end=%0b drag_end=%0b collect=%0b, want no pulse",
                         drop_end, drag_end, collect);
            end else begin
                e = exp_q.pop_front();
                if ({drop_end, drag_end, length, angle, collect, collect_gold} !==
                    {~e.is_drag, e.is_drag, e.len, e.ang, e.coll, e.cgold}) begin
                    n_fail++;
                    $display("FAIL scoreboard_event: got drop_end=%0b drag_end=%0b len=%0d angle=%0d collect=%0b gold=%0b, want drop_end=%0b drag_end=%0b len=%0d angle=%0d collect=%0b gold=%0b",
                             drop_end, drag_end, length, angle, collect, collect_gold,
                             ~e.is_drag, e.is_drag, e.len, e.ang, e.coll, e.cgold);
                end
            end
            $display("event: drop_end=%0b drag_end=%0b len=%0d angle=%0d collect=%0b gold=%0b",
                     drop_end, drag_end, length, angle, collect, collect_gold);
        end else if (collect) begin
            n_checks++;
            n_fail++;
            $display("FAIL stray_collect: got collect=1 without drag_end, want 0");
        end
    endtask

    task automatic frames(input int n);
        frame = 1'b1;
        repeat (n) cyc();
        frame = 1'b0;
    endtask

    task automatic wait_ev(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            cyc();
            seen = drop_end || drag_end;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        n_checks++;
        if ({angle, length, clockwise, busy, drop_end, drag_end, collect, collect_gold} !==
            {7'd40, 8'd16, 1'b1, 1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_values: got angle=%0d len=%0d cw=%0b busy=%0b pulses=%0b%0b%0b%0b, want 40 16 1 0 0000",
                     angle, length, clockwise, busy, drop_end, drag_end, collect, collect_gold);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cyc();
        $display("reset: angle=%0d len=%0d cw=%0b", angle, length, clockwise);
    endtask

    task automatic test_swing();
        frames(40);
        n_checks++;
        if ({angle, clockwise} !== {7'd80, 1'b0}) begin
            n_fail++;
            $display("FAIL swing_max: got angle=%0d cw=%0b, want 80 0", angle, clockwise);
        end
        frames(1);
        n_checks++;
        if (angle !== 7'd79) begin
            n_fail++;
            $display("FAIL swing_turn: got angle=%0d, want 79", angle);
        end
        frames(79);
        n_checks++;
        if ({angle, clockwise} !== {7'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL swing_zero: got angle=%0d cw=%0b, want 0 1", angle, clockwise);
        end
        frames(40);
        n_checks++;
        if ({angle, clockwise} !== {7'd40, 1'b1}) begin
            n_fail++;
            $display("FAIL swing_center: got angle=%0d cw=%0b, want 40 1", angle, clockwise);
        end
        $display("swing: angle=%0d cw=%0b", angle, clockwise);
    endtask

    // Full empty extension and retraction at the current angle.
    task automatic test_empty_drop(input string tag);
        bit seen;
        logic [6:0] a0;
        a0 = angle;
        exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b0, 8'd120, a0));
        drop = 1'b1;
        cyc();
        drop = 1'b0;
        n_checks++;
        if ({busy, length} !== {1'b1, 8'd16}) begin
            n_fail++;
            $display("FAIL %s_enter: got busy=%0b len=%0d, want 1 16", tag, busy, length);
        end
        frames(1);
        n_checks++;
        if (length !== 8'd20) begin
            n_fail++;
            $display("FAIL %s_first_frame: got len=%0d, want 20", tag, length);
        end
        frames(25);
        n_checks++;
        if ({length, busy, angle} !== {8'd120, 1'b1, a0}) begin
            n_fail++;
            $display("FAIL %s_extended: got len=%0d busy=%0b angle=%0d, want 120 1 %0d", tag, length, busy, angle, a0);
        end
        wait_ev(4, seen);
        n_checks++;
        if (!seen || !drop_end) begin
            n_fail++;
            $display("FAIL %s_drop_end: got seen=%0b drop_end=%0b, want 1 1", tag, seen, drop_end);
        end
        exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 8'd16, a0));
        frames(26);
        n_checks++;
        if ({length, busy} !== {8'd16, 1'b1}) begin
            n_fail++;
            $display("FAIL %s_retracted: got len=%0d busy=%0b, want 16 1", tag, length, busy);
        end
        wait_ev(4, seen);
        n_checks++;
        if (!seen || !drag_end || busy !== 1'b0 || angle !== a0) begin
            n_fail++;
            $display("FAIL %s_drag_end: got seen=%0b drag_end=%0b busy=%0b angle=%0d, want 1 1 0 %0d",
                     tag, seen, drag_end, busy, angle, a0);
        end
        $display("%s: done at angle=%0d len=%0d", tag, angle, length);
    endtask

    task automatic test_stone();
        bit seen;
        int nf;
        exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b0, 8'd40, 7'd40));
        drop = 1'b1;
        cyc();
        drop = 1'b0;
        frames(6);
        hit = 1'b1;
        hit_gold = 1'b0;
        cyc();
        hit = 1'b0;
        n_checks++;
        if ({busy, length, drop_end} !== {1'b1, 8'd40, 1'b1}) begin
            n_fail++;
            $display("FAIL stone_hit: got busy=%0b len=%0d drop_end=%0b, want 1 40 1", busy, length, drop_end);
        end
        exp_q.push_back(mk_ev(1'b1, 1'b1, 1'b0, 8'd16, 7'd40));
        nf = 24 / STONE_STEP;
        for (int k = 1; k <= nf; k++) begin
            frames(1);
            n_checks++;
            if (length !== 8'(40 - k * STONE_STEP)) begin
                n_fail++;
                $display("FAIL stone_drag_len: frame %0d got len=%0d, want %0d", k, length, 40 - k * STONE_STEP);
            end
        end
        wait_ev(4, seen);
        n_checks++;
        if (!seen || !collect) begin
            n_fail++;
            $display("FAIL stone_collect: got seen=%0b collect=%0b, want 1 1", seen, collect);
        end
        $display("stone: %0d retract frames", nf);
    endtask

    task automatic test_priority();
        bit seen;
        exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b0, 8'd60, 7'd40));
        drop = 1'b1;
        cyc();
        drop = 1'b0;
        frames(11);
        frame = 1'b1;
        hit = 1'b1;
        hit_gold = 1'b1;
        cyc();
        frame = 1'b0;
        hit = 1'b0;
        n_checks++;
        if ({length, busy, drop_end} !== {8'd60, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL hit_over_frame: got len=%0d busy=%0b drop_end=%0b, want 60 1 1", length, busy, drop_end);
        end
        exp_q.push_back(mk_ev(1'b1, 1'b1, 1'b1, 8'd16, 7'd40));
        frames(11);
        n_checks++;
        if (length !== 8'd16) begin
            n_fail++;
            $display("FAIL gold_drag_len: got len=%0d, want 16", length);
        end
        wait_ev(4, seen);
        n_checks++;
        if (!seen || {collect, collect_gold} !== 2'b11) begin
            n_fail++;
            $display("FAIL gold_collect: got seen=%0b collect=%0b gold=%0b, want 1 1 1", seen, collect, collect_gold);
        end
        $display("priority: hit held length at 60");
    endtask

    task automatic test_ignored_halt();
        bit seen;
        exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b0, 8'd24, 7'd40));
        drop = 1'b1;
        cyc();
        drop = 1'b0;
        frames(2);
        hit = 1'b1;
        hit_gold = 1'b0;
        cyc();
        hit = 1'b0;
        drop = 1'b1;
        cyc();
        drop = 1'b0;
        n_checks++;
        if ({length, busy, angle} !== {8'd24, 1'b1, 7'd40}) begin
            n_fail++;
            $display("FAIL drop_in_drag: got len=%0d busy=%0b angle=%0d, want 24 1 40", length, busy, angle);
        end
        exp_q.push_back(mk_ev(1'b1, 1'b1, 1'b0, 8'd16, 7'd40));
        frames(8 / STONE_STEP);
        wait_ev(4, seen);
        n_checks++;
        if (!seen || !drag_end) begin
            n_fail++;
            $display("FAIL ignored_drag_end: got seen=%0b drag_end=%0b, want 1 1", seen, drag_end);
        end
        repeat (3) cyc();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_not_queued: got busy=%0b, want 0", busy);
        end
        frames(3);
        drop = 1'b1;
        cyc();
        drop = 1'b0;
        frames(16);
        n_checks++;
        if ({length, angle} !== {8'd80, 7'd43}) begin
            n_fail++;
            $display("FAIL halt_setup: got len=%0d angle=%0d, want 80 43", length, angle);
        end
        game_end = 1'b1;
        cyc();
        n_checks++;
        if ({length, busy, angle} !== {8'd16, 1'b0, 7'd43}) begin
            n_fail++;
            $display("FAIL halt_enter: got len=%0d busy=%0b angle=%0d, want 16 0 43", length, busy, angle);
        end
        drop = 1'b1;
        frame = 1'b1;
        cyc();
        drop = 1'b0;
        frame = 1'b0;
        cyc();
        n_checks++;
        if ({length, busy, angle} !== {8'd16, 1'b0, 7'd43}) begin
            n_fail++;
            $display("FAIL halt_hold: got len=%0d busy=%0b angle=%0d, want 16 0 43", length, busy, angle);
        end
        game_end = 1'b0;
        cyc();
        n_checks++;
        if ({angle, clockwise, busy} !== {7'd40, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_release: got angle=%0d cw=%0b busy=%0b, want 40 1 0", angle, clockwise, busy);
        end
        cyc();
        $display("halt: released at angle=%0d", angle);
    endtask

    task automatic test_async_reset();
        exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b0, 8'd36, 7'd40));
        drop = 1'b1;
        cyc();
        drop = 1'b0;
        frames(5);
        hit = 1'b1;
        hit_gold = 1'b1;
        cyc();
        hit = 1'b0;
        frames(2);
        n_checks++;
        if ({length, busy} !== {8'd28, 1'b1}) begin
            n_fail++;
            $display("FAIL areset_setup: got len=%0d busy=%0b, want 28 1", length, busy);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({angle, length, clockwise, busy, drag_end, collect} !== {7'd40, 8'd16, 1'b1, 1'b0, 2'b00}) begin
            n_fail++;
            $display("FAIL areset_immediate: got angle=%0d len=%0d cw=%0b busy=%0b drag_end=%0b collect=%0b, want 40 16 1 0 0 0",
                     angle, length, clockwise, busy, drag_end, collect);
        end
        cyc();
        resetn = 1'b1;
        repeat (6) cyc();
        $display("areset: carried gold discarded");
    endtask

    initial begin
        test_reset();
        test_swing();
        test_empty_drop("empty_drop");
        test_stone();
        test_priority();
        test_ignored_halt();
        test_async_reset();
        test_empty_drop("post_reset_drop");
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending events, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
